// File: rtl/universal_shift_register.sv
// Parametrised universal shift register: hold / shift-left / shift-right / parallel-load,
// registered serial output and a frame counter. Define UNIVERSAL_SHIFT_ROTATE_EN to add the ROT input.
module universal_shift_register #(
    parameter int  WIDTH     = 16,
    parameter int  FRAME_LEN = 16,
    localparam int CW        = $clog2(FRAME_LEN)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             IN,
`ifdef UNIVERSAL_SHIFT_ROTATE_EN
    input  logic             ROT,
`endif
    input  logic [WIDTH-1:0] PIN,
    output logic [WIDTH-1:0] OUT,
    output logic             SOUT,
    output logic [CW-1:0]    COUNT,
    output logic             FRAME_DONE
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    localparam logic [CW-1:0] LAST_COUNT = CW'(FRAME_LEN - 1);

    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic [CW-1:0]    count_q, count_d;
    logic             frameDone_q, frameDone_d;
    logic             shiftEvent;
    logic             rotate;
    mode_e            modeSel;

`ifdef UNIVERSAL_SHIFT_ROTATE_EN
    assign rotate = ROT;
`else
    assign rotate = 1'b0;
`endif

    assign modeSel = mode_e'(MODE);

    // Next-state: rotate recirculates the outgoing bit instead of taking IN; counter advances on any shift.
    always_comb begin
        data_d      = data_q;
        sout_d      = sout_q;
        count_d     = count_q;
        frameDone_d = 1'b0;
        shiftEvent  = 1'b0;
        if (EN) begin
            unique case (modeSel)
                MODE_LEFT: begin
                    data_d     = {data_q[WIDTH-2:0], rotate ? data_q[WIDTH-1] : IN};
                    sout_d     = data_q[WIDTH-1];
                    shiftEvent = 1'b1;
                end
                MODE_RIGHT: begin
                    data_d     = {rotate ? data_q[0] : IN, data_q[WIDTH-1:1]};
                    sout_d     = data_q[0];
                    shiftEvent = 1'b1;
                end
                MODE_LOAD: begin
                    data_d  = PIN;
                    count_d = '0;
                end
                MODE_HOLD: begin
                end
            endcase
        end
        if (shiftEvent) begin
            if (count_q == LAST_COUNT) begin
                count_d     = '0;
                frameDone_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            data_q      <= '0;
            sout_q      <= 1'b0;
            count_q     <= '0;
            frameDone_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            sout_q      <= sout_d;
            count_q     <= count_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign OUT        = data_q;
    assign SOUT       = sout_q;
    assign COUNT      = count_q;
    assign FRAME_DONE = frameDone_q;

endmodule

// File: tb/tb_universal_shift_register.sv
// Self-checking bench for universal_shift_register (WIDTH=16, FRAME_LEN=16): directed scenarios
// plus randomized traffic compared against an arithmetic reference model.
module tb_universal_shift_register;

    localparam int WIDTH     = 16;
    localparam int FRAME_LEN = 16;
    localparam int CW        = $clog2(FRAME_LEN);
    localparam int FULL      = 2 ** WIDTH;
    localparam int HALF      = 2 ** (WIDTH - 1);

    logic             clk;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic             inBit;
    logic             rot;
    logic [WIDTH-1:0] pin;
    logic [WIDTH-1:0] outBus;
    logic             sout;
    logic [CW-1:0]    count;
    logic             frameDone;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: register value as a plain integer, shifts done with * and /.
    int mOut   = 0;
    int mSout  = 0;
    int mCount = 0;
    int mDone  = 0;

    universal_shift_register #(
        .WIDTH(WIDTH),
        .FRAME_LEN(FRAME_LEN)
    ) dut (
        .CLK(clk),
        .RESET(reset),
        .EN(en),
        .MODE(mode),
        .IN(inBit),
`ifdef UNIVERSAL_SHIFT_ROTATE_EN
        .ROT(rot),
`endif
        .PIN(pin),
        .OUT(outBus),
        .SOUT(sout),
        .COUNT(count),
        .FRAME_DONE(frameDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic modelFrameStep();
        mCount = mCount + 1;
        if (mCount == FRAME_LEN) begin
            mCount = 0;
            mDone  = 1;
        end else begin
            mDone = 0;
        end
    endtask

    task automatic modelUpdate(input logic r, input logic e, input logic [1:0] m,
                               input logic i, input logic [WIDTH-1:0] p, input logic ro);
        int outgoing;
        int incoming;
        int useRot;
`ifdef UNIVERSAL_SHIFT_ROTATE_EN
        useRot = int'(ro);
`else
        useRot = 0;
`endif
        if (r) begin
            mOut = 0; mSout = 0; mCount = 0; mDone = 0;
        end else if (!e) begin
            mDone = 0;
        end else begin
            case (m)
                2'd1: begin
                    outgoing = mOut / HALF;
                    incoming = useRot ? outgoing : int'(i);
                    mOut     = (mOut % HALF) * 2 + incoming;
                    mSout    = outgoing;
                    modelFrameStep();
                end
                2'd2: begin
                    outgoing = mOut % 2;
                    incoming = useRot ? outgoing : int'(i);
                    mOut     = mOut / 2 + incoming * HALF;
                    mSout    = outgoing;
                    modelFrameStep();
                end
                2'd3: begin
                    mOut = int'(p); mCount = 0; mDone = 0;
                end
                default: mDone = 0;
            endcase
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, and leave time 1 unit past the edge.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m,
                                 input logic i, input logic [WIDTH-1:0] p, input logic ro);
        reset = r; en = e; mode = m; inBit = i; pin = p; rot = ro;
        @(posedge clk);
        modelUpdate(r, e, m, i, p, ro);
        #1;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b0);
        vectors++;
        if (outBus !== 16'h0000 || sout !== 1'b0 || count !== 4'd0 || frameDone !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset: got OUT=%h SOUT=%b COUNT=%0d FD=%b, expected 0000/0/0/0",
                     outBus, sout, count, frameDone);
        end
    endtask

    task automatic test_shift_left();
        logic [3:0] bits;
        bits = 4'b1101;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, bits[k], '0, 1'b0);
            vectors++;
            if (frameDone !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL shl_fd step %0d: got %b, expected 0", k, frameDone);
            end
        end
        vectors++;
        if (outBus !== 16'h000B || count !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL shl_result: got OUT=%h COUNT=%0d, expected 000B/4", outBus, count);
        end
    endtask

    task automatic test_load_shift_right();
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 16'hA5F0, 1'b0);
        vectors++;
        if (outBus !== 16'hA5F0 || count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL load: got OUT=%h COUNT=%0d, expected A5F0/0", outBus, count);
        end
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, '0, 1'b0);
        vectors++;
        if (outBus !== 16'h52F8 || sout !== 1'b0 || count !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL shr: got OUT=%h SOUT=%b COUNT=%0d, expected 52F8/0/1",
                     outBus, sout, count);
        end
    endtask

    task automatic test_frame();
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, '0, 1'b0);
            vectors++;
            if (frameDone !== (k == 16)) begin
                miscompares++;
                $display("[TB] FAIL frame_fd shift %0d: got %b, expected %b", k, frameDone, k == 16);
            end
        end
        vectors++;
        if (outBus !== 16'hFFFF || count !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL frame_wrap: got OUT=%h COUNT=%0d, expected FFFF/0", outBus, count);
        end
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, '0, 1'b0);
        vectors++;
        if (frameDone !== 1'b0 || count !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL frame_17th: got FD=%b COUNT=%0d, expected 0/1", frameDone, count);
        end
    endtask

    task automatic test_enable_hold();
        logic [WIDTH-1:0] heldOut;
        logic             heldSout;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 5; k++) applyStimulus(1'b0, 1'b1, 2'd1, k[0], '0, 1'b0);
        heldOut  = outBus;
        heldSout = sout;
        vectors++;
        if (outBus !== 16'h000A || count !== 4'd5) begin
            miscompares++;
            $display("[TB] FAIL hold_pre: got OUT=%h COUNT=%0d, expected 000A/5", outBus, count);
        end
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 2'd1, 1'b1, '0, 1'b0);
            vectors++;
            if (outBus !== heldOut || sout !== heldSout || count !== 4'd5 || frameDone !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL hold cycle %0d: got OUT=%h SOUT=%b COUNT=%0d FD=%b, expected %h/%b/5/0",
                         k, outBus, sout, count, frameDone, heldOut, heldSout);
            end
        end
    endtask

    task automatic test_reset_priority();
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 16'h1234, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0, 16'hFFFF, 1'b0);
        vectors++;
        if (outBus !== 16'h0000 || count !== 4'd0 || sout !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_prio: got OUT=%h COUNT=%0d SOUT=%b, expected 0000/0/0",
                     outBus, count, sout);
        end
    endtask

`ifdef UNIVERSAL_SHIFT_ROTATE_EN
    task automatic test_rotate();
        applyStimulus(1'b0, 1'b1, 2'd3, 1'b0, 16'h8001, 1'b0);
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, '0, 1'b1);
        vectors++;
        if (outBus !== 16'h0003 || sout !== 1'b1 || count !== 4'd1) begin
            miscompares++;
            $display("[TB] FAIL rotate: got OUT=%h SOUT=%b COUNT=%0d, expected 0003/1/1",
                     outBus, sout, count);
        end
    endtask
`endif

    task automatic test_random();
        logic             r;
        logic             e;
        logic [1:0]       m;
        logic [WIDTH-1:0] p;
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0, '0, 1'b0);
        for (int k = 0; k < 400; k++) begin
            r = ($urandom_range(0, 49) == 0);
            e = ($urandom_range(0, 5) != 0);
            // Bias towards shifts so frames complete regularly; loads stay rare.
            case ($urandom_range(0, 9))
                0:       m = 2'd0;
                1:       m = 2'd3;
                2, 3, 4: m = 2'd2;
                default: m = 2'd1;
            endcase
            p = WIDTH'($urandom);
            applyStimulus(r, e, m, 1'($urandom), p, 1'($urandom));
            vectors++;
            if (int'(outBus) !== mOut || int'(sout) !== mSout ||
                int'(count) !== mCount || int'(frameDone) !== mDone) begin
                miscompares++;
                $display("[TB] FAIL random cycle %0d: got OUT=%h SOUT=%b COUNT=%0d FD=%b, expected %h/%0d/%0d/%0d",
                         k, outBus, sout, count, frameDone, mOut[WIDTH-1:0], mSout, mCount, mDone);
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 2'd0; inBit = 1'b0; pin = '0; rot = 1'b0;
        test_reset();
        test_shift_left();
        test_load_shift_right();
        test_frame();
        test_enable_hold();
        test_reset_priority();
`ifdef UNIVERSAL_SHIFT_ROTATE_EN
        test_rotate();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
Parametrised successor to the team's 16-bit serial-in/parallel-out shift register. Adds:
- configurable width
- shift-left, shift-right, parallel-load and hold modes
- clock enable and synchronous reset
- serial output
- frame counter that pulses when a full frame of bits has been shifted

Used as the serialiser/deserialiser front end for bit-serial links and LED/display chains.

Parameters:
WIDTH, 16, register width in bits (>= 2)
FRAME_LEN, 16, number of enabled shifts per frame (>= 2); sets the FRAME_DONE period
CW, $clog2(FRAME_LEN), width of COUNT (localparam, derived)

Ports:
CLK  input  1  rising-edge clock, only clock in the block
RESET  input  1  synchronous, active-high reset
EN  input  1  clock enable; when low, all state holds
MODE  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load
IN  input  1  serial data input
PIN  input  WIDTH  parallel load data
OUT  output  WIDTH  register contents (registered)
SOUT  output  1  last bit shifted out (registered)
COUNT  output  CW  shifts completed in the current frame
FRAME_DONE  output  1  one-cycle pulse on frame completion (registered)

Behaviour:
- One clock (CLK) only; RESET is synchronous and active-high, sampled on the rising CLK edge.
- Reset: OUT=0, SOUT=0, COUNT=0, FRAME_DONE=0.
- Priority: RESET over EN over MODE. A RESET edge mid-frame discards the partial frame with no FRAME_DONE.
- EN=0: OUT, SOUT and COUNT hold; FRAME_DONE=0.
- All results appear one cycle after the sampling edge. There is no combinational path from inputs to outputs.
- MODE 01, shift left:
  - OUT <= {OUT[WIDTH-2:0], IN}; SOUT <= OUT[WIDTH-1].
  - Bit-compatible with the existing 16-bit block when WIDTH=16.
- MODE 10, shift right: OUT <= {IN, OUT[WIDTH-1:1]}; SOUT <= OUT[0].
- MODE 11, parallel load: OUT <= PIN; COUNT <= 0; SOUT holds; FRAME_DONE=0.
- MODE 00, hold: OUT, SOUT and COUNT hold; FRAME_DONE=0.
- Frame counter, counting every enabled shift (modes 01 and 10):
  - If COUNT < FRAME_LEN-1: COUNT <= COUNT+1 and FRAME_DONE <= 0.
  - If COUNT == FRAME_LEN-1: COUNT <= 0 (wrap) and FRAME_DONE <= 1 for exactly one cycle, on the same edge as the completing shift.
  - Back-to-back frames therefore give FRAME_DONE every FRAME_LEN enabled shifts.
- Switching between left and right shift mid-frame does not clear COUNT. Only load and reset clear it.
- FRAME_DONE is 0 in every cycle that is not a frame-completing shift.

Optional Feature:
Macro: UNIVERSAL_SHIFT_ROTATE_EN

- Defined:
  - Extra input port ROT (1 bit).
  - When ROT=1 during a shift, IN is ignored and the outgoing bit re-enters the register:
    - shift left: OUT <= {OUT[WIDTH-2:0], OUT[WIDTH-1]}
    - shift right: OUT <= {OUT[0], OUT[WIDTH-1:1]}
  - SOUT and COUNT behave exactly as for a normal shift.
  - When ROT=0, behaviour is identical to the undefined case.
- Undefined: the ROT port does not exist; shifts always take IN.

Test Plan:
All scenarios use WIDTH=16, FRAME_LEN=16.

1. RESET for one edge, then EN=1, MODE=01, IN=1,0,1,1 over 4 edges -> OUT=16'h000B, COUNT=4, FRAME_DONE=0 throughout.
2. MODE=11 with PIN=16'hA5F0 -> OUT=16'hA5F0 and COUNT=0. Next edge MODE=10, IN=0 -> OUT=16'h52F8, SOUT=0, COUNT=1.
3. From reset, 16 consecutive left shifts with IN=1:
   - After the 16th edge: OUT=16'hFFFF, FRAME_DONE=1 for that cycle only, COUNT=0.
   - 17th shift: FRAME_DONE=0, COUNT=1.
4. Mid-frame at COUNT=5, hold EN=0 with MODE=01 for 5 cycles -> OUT, SOUT and COUNT=5 unchanged; FRAME_DONE=0.
5. RESET=1 in the same cycle as EN=1, MODE=11, PIN=16'hFFFF -> OUT=16'h0000, COUNT=0, SOUT=0 after the edge.
6. With UNIVERSAL_SHIFT_ROTATE_EN defined: load 16'h8001, then MODE=01, ROT=1, IN=0 -> OUT=16'h0003, SOUT=1, COUNT=1.
